// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared CPU definitions used by the fetch stage and its neighbours:
//   - fetch_state_e    : fetch FSM state encoding
//   - RESET_PC_DEFAULT : default first fetch address after reset
//   - NOP_INST         : canonical NOP (addi x0, x0, 0)
//   - align_pc()       : force a word-aligned fetch address
//   - next_pc()        : sequential successor, wraps modulo 2^32
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // issuing a request to instruction memory
    S_WAIT = 2'd1,  // one request outstanding, awaiting its response
    S_FULL = 2'd2   // holding an instruction for decode
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  // Clear the two byte-offset bits; masking keeps every input bit in use.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

  // 32-bit addition drops the carry, so 0xFFFF_FFFC is followed by 0x0.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Single-issue instruction fetch stage. Keeps one request outstanding to the
// instruction memory, registers the returned word for decode and handles
// redirects from execute by discarding in-flight or held instructions.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   imem_req_valid    out  fetch request valid
//   imem_req_ready    in   memory accepts the request this cycle
//   imem_req_addr     out  fetch address (the internal pc)
//   imem_rsp_valid    in   memory response valid
//   imem_rsp_data     in   fetched instruction word
//   if_valid          out  if_inst/if_pc hold an instruction for decode
//   if_ready          in   decode consumes the instruction this cycle
//   if_inst, if_pc    out  instruction and its address
//   redirect_valid    in   execute requests a pc change
//   redirect_pc       in   new fetch address (low two bits ignored)
// -----------------------------------------------------------------------------
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic [31:0]  if_inst_q, if_inst_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic         req_valid_q, req_valid_d;
  logic         if_valid_q, if_valid_d;
  logic         accept_s;

  // A request is only accepted while it is actually being presented; right
  // after reset release req_valid_q is still low for one cycle.
  assign accept_s = req_valid_q & imem_req_ready;

  // Next-state, pc, drop-flag and decode-register logic; redirect wins.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    if_inst_d = if_inst_q;
    if_pc_d   = if_pc_q;

    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
      case (state_q)
        S_REQ: begin
          if (accept_s) begin
            // The request just issued carries the old pc: drop its response.
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            // Response arrives with the redirect: discard it right away.
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end
        S_FULL: begin
          state_d = S_REQ;
        end
        default: begin
          state_d = S_REQ;
          drop_d  = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (accept_s) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              // Stale response from before a redirect; pc already updated.
              state_d = S_REQ;
              drop_d  = 1'b0;
            end else begin
              state_d   = S_FULL;
              if_inst_d = imem_rsp_data;
              if_pc_d   = pc_q;
              pc_d      = next_pc(pc_q);
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_FULL: begin
          if (if_ready) begin
            state_d = S_REQ;
          end else begin
            state_d = S_FULL;
          end
        end
        default: begin
          state_d = S_REQ;
          drop_d  = 1'b0;
        end
      endcase
    end

    // Output valids are registered copies of the next state's decode.
    req_valid_d = (state_d == S_REQ);
    if_valid_d  = (state_d == S_FULL);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      if_inst_q   <= 32'h0000_0000;
      if_pc_q     <= 32'h0000_0000;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      if_inst_q   <= if_inst_d;
      if_pc_q     <= if_pc_d;
      req_valid_q <= req_valid_d;
      if_valid_q  <= if_valid_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_inst        = if_inst_q;
  assign if_pc          = if_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  inst_fetch #(.RESET_PC(32'h0040_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    bit seen;
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hA000_0000;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;

    // Reset state
    step(2);
    chk1 ("rst_req_valid", imem_req_valid, 1'b0);
    chk1 ("rst_if_valid",  if_valid,       1'b0);
    chk32("rst_req_addr",  imem_req_addr,  32'h0040_0000);
    chk32("rst_if_inst",   if_inst,        32'h0000_0000);
    chk32("rst_if_pc",     if_pc,          32'h0000_0000);
    rst = 1'b0;

    // Zero-wait memory, decode always ready: 3-cycle spacing
    step(1);
    chk1 ("first_req_valid", imem_req_valid, 1'b1);
    chk32("first_req_addr",  imem_req_addr,  32'h0040_0000);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (if_valid) begin
        seen = 1'b1;
        break;
      end
      step(1);
    end
    chk1 ("first_if_valid", seen, 1'b1);
    chk32("seq0_if_pc",   if_pc,   32'h0040_0000);
    chk32("seq0_if_inst", if_inst, 32'hA000_0000);
    imem_rsp_data = 32'hA000_0004;
    step(1);
    chk1 ("seq_gap_if_valid", if_valid,      1'b0);
    chk32("seq1_req_addr",    imem_req_addr, 32'h0040_0004);
    step(2);
    chk1 ("seq1_if_valid", if_valid, 1'b1);
    chk32("seq1_if_pc",    if_pc,    32'h0040_0004);
    chk32("seq1_if_inst",  if_inst,  32'hA000_0004);
    imem_rsp_data = 32'hA000_0008;
    step(3);
    chk1 ("seq2_if_valid", if_valid, 1'b1);
    chk32("seq2_if_pc",    if_pc,    32'h0040_0008);
    chk32("seq2_if_inst",  if_inst,  32'hA000_0008);

    // Decode stalls for 5 cycles on 0x00200093
    step(1);
    chk32("stall_req_addr", imem_req_addr, 32'h0040_000C);
    imem_rsp_data = 32'h0020_0093;
    if_ready      = 1'b0;
    step(2);
    imem_rsp_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      chk1 ("stall_if_valid",  if_valid,       1'b1);
      chk32("stall_if_inst",   if_inst,        32'h0020_0093);
      chk32("stall_if_pc",     if_pc,          32'h0040_000C);
      chk1 ("stall_req_valid", imem_req_valid, 1'b0);
      step(1);
    end
    if_ready = 1'b1;
    step(1);
    chk1 ("post_stall_if_valid", if_valid,      1'b0);
    chk32("post_stall_req_addr", imem_req_addr, 32'h0040_0010);

    // Redirect while waiting, response two cycles later is dropped
    imem_rsp_valid = 1'b0;
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0100;
    step(1);
    redirect_valid = 1'b0;
    chk1("rw_req_valid", imem_req_valid, 1'b0);
    chk1("rw_if_valid0", if_valid,       1'b0);
    step(1);
    chk1("rw_if_valid1", if_valid, 1'b0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = NOP_INST;
    step(1);
    chk1 ("rw_if_valid2",  if_valid,       1'b0);
    chk1 ("rw_req_valid2", imem_req_valid, 1'b1);
    chk32("rw_req_addr",   imem_req_addr,  32'h0040_0100);
    imem_rsp_data = 32'hC000_0100;
    step(2);
    chk1 ("rw_fetch_valid", if_valid, 1'b1);
    chk32("rw_fetch_pc",    if_pc,    32'h0040_0100);
    chk32("rw_fetch_inst",  if_inst,  32'hC000_0100);
    step(1);
    chk32("rw_next_addr", imem_req_addr, 32'h0040_0104);

    // Redirect (unaligned) in the same cycle as a response
    imem_rsp_data = NOP_INST;
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0103;
    step(1);
    redirect_valid = 1'b0;
    chk1 ("rs_if_valid",  if_valid,       1'b0);
    chk1 ("rs_req_valid", imem_req_valid, 1'b1);
    chk32("rs_req_addr",  imem_req_addr,  32'h0040_0100);
    imem_rsp_data = 32'hC000_0200;
    step(2);
    chk32("rs_fetch_pc",   if_pc,   32'h0040_0100);
    chk32("rs_fetch_inst", if_inst, 32'hC000_0200);
    step(1);
    chk32("rs_next_addr", imem_req_addr, 32'h0040_0104);

    // Redirect to 0xFFFFFFFC in S_REQ while memory not ready, then wrap
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    chk1 ("wrap_req_valid", imem_req_valid, 1'b1);
    chk32("wrap_req_addr",  imem_req_addr,  32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    imem_rsp_data  = 32'hC000_0300;
    step(2);
    chk1 ("wrap_if_valid", if_valid, 1'b1);
    chk32("wrap_if_pc",    if_pc,    32'hFFFF_FFFC);
    chk32("wrap_if_inst",  if_inst,  32'hC000_0300);
    step(1);
    chk32("wrap_next_addr", imem_req_addr, 32'h0000_0000);

    // Redirect in S_REQ while the request is accepted: its response drops
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0200;
    imem_rsp_data  = NOP_INST;
    step(1);
    redirect_valid = 1'b0;
    chk1("ra_req_valid", imem_req_valid, 1'b0);
    chk1("ra_if_valid",  if_valid,       1'b0);
    step(1);
    chk1 ("ra_if_valid2", if_valid,       1'b0);
    chk1 ("ra_req_valid2",imem_req_valid, 1'b1);
    chk32("ra_req_addr",  imem_req_addr,  32'h0040_0200);
    imem_rsp_data = 32'hC000_0400;
    step(2);
    chk32("ra_fetch_pc",   if_pc,   32'h0040_0200);
    chk32("ra_fetch_inst", if_inst, 32'hC000_0400);

    // Redirect while holding an instruction that decode has not taken
    if_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0300;
    step(1);
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    chk1 ("rf_if_valid",  if_valid,       1'b0);
    chk1 ("rf_req_valid", imem_req_valid, 1'b1);
    chk32("rf_req_addr",  imem_req_addr,  32'h0040_0300);

    // Asynchronous reset in S_WAIT, stale response afterwards
    imem_rsp_valid = 1'b0;
    step(1);
    chk1("ar_in_wait", imem_req_valid, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk1 ("ar_if_valid",  if_valid,       1'b0);
    chk1 ("ar_req_valid", imem_req_valid, 1'b0);
    chk32("ar_req_addr",  imem_req_addr,  32'h0040_0000);
    chk32("ar_if_pc",     if_pc,          32'h0000_0000);
    step(1);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = NOP_INST;
    rst            = 1'b0;
    step(1);
    chk1 ("ar_post_req_valid", imem_req_valid, 1'b1);
    chk32("ar_post_req_addr",  imem_req_addr,  32'h0040_0000);
    chk1 ("ar_post_if_valid",  if_valid,       1'b0);
    imem_rsp_valid = 1'b0;
    step(1);
    chk1("ar_wait_if_valid", if_valid, 1'b0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hC000_0500;
    step(1);
    chk1 ("ar_fetch_valid", if_valid, 1'b1);
    chk32("ar_fetch_pc",    if_pc,    32'h0040_0000);
    chk32("ar_fetch_inst",  if_inst,  32'hC000_0500);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
